// File: rtl/unidad_control_if.sv
// Control-unit signal bundle: program inputs in, datapath/memory strobes out.
// The control unit connects through the master modport and the datapath through the slave modport.
interface unidad_control_if;
  logic       run;
  logic [3:0] ir_opcode;
  logic       pc_clr;
  logic       pc_inc;
  logic       pc_load;
  logic       addr_sel;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_load;
  logic       acc_load;
  logic [3:0] alu_op;
  logic       loader_grant;
  logic       halted;
  logic       instr_done;
  logic [2:0] state;

  modport master (
    input  run, ir_opcode,
    output pc_clr, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, ir_load, acc_load,
    output alu_op, loader_grant, halted, instr_done, state
  );

  modport slave (
    output run, ir_opcode,
    input  pc_clr, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, ir_load, acc_load,
    input  alu_op, loader_grant, halted, instr_done, state
  );
endinterface

// File: rtl/unidad_control.sv
// Multi-cycle accumulator CPU control FSM with configurable memory read latency (MEM_LAT 1..4).
// All outputs are Moore outputs of the registered state, wait counter and ir_opcode.
module unidad_control #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  unidad_control_if.master ctl
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StFetch  = 3'd2,
    StDecode = 3'd3,
    StRead   = 3'd4,
    StExec   = 3'd5,
    StWrite  = 3'd6,
    StHalt   = 3'd7
  } state_e;

  localparam logic [3:0] OpHalt  = 4'h0;
  localparam logic [3:0] OpStore = 4'h2;
  localparam logic [3:0] OpJmp   = 4'hB;
  localparam logic [1:0] WaitInit = 2'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] wait_q, wait_d;
  logic       wait_done;

  assign wait_done = (wait_q == 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (ctl.run) state_d = StClear;
      end
      StClear: begin
        state_d = StFetch;
        wait_d  = WaitInit;
      end
      StFetch: begin
        if (wait_done) state_d = StDecode;
        else           wait_d  = wait_q - 2'd1;
      end
      StDecode: begin
        if (ctl.ir_opcode == OpHalt) begin
          state_d = StHalt;
        end else if (ctl.ir_opcode == OpStore) begin
          state_d = StWrite;
        end else begin
          state_d = StRead;
          wait_d  = WaitInit;
        end
      end
      StRead: begin
        if (wait_done) state_d = StExec;
        else           wait_d  = wait_q - 2'd1;
      end
      // run only matters at instruction boundaries; a started instruction always retires
      StExec, StWrite: begin
        if (ctl.run) begin
          state_d = StFetch;
          wait_d  = WaitInit;
        end else begin
          state_d = StIdle;
        end
      end
      StHalt: begin
        if (!ctl.run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic       pc_clr, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, ir_load, acc_load;
  logic       loader_grant, halted, instr_done;
  logic [3:0] alu_op;

  always_comb begin
    pc_clr       = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    addr_sel     = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    ir_load      = 1'b0;
    acc_load     = 1'b0;
    loader_grant = 1'b0;
    halted       = 1'b0;
    instr_done   = 1'b0;
    alu_op       = 4'h0;
    unique case (state_q)
      StIdle:   loader_grant = 1'b1;
      StClear:  pc_clr = 1'b1;
      StFetch: begin
        mem_rd  = 1'b1;
        ir_load = wait_done;
      end
      StDecode: pc_inc = (ctl.ir_opcode != OpHalt);
      StRead: begin
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
      end
      StExec: begin
        alu_op     = ctl.ir_opcode;
        pc_load    = (ctl.ir_opcode == OpJmp);
        acc_load   = (ctl.ir_opcode != OpJmp);
        instr_done = 1'b1;
      end
      StWrite: begin
        addr_sel   = 1'b1;
        mem_wr     = 1'b1;
        instr_done = 1'b1;
      end
      StHalt:   halted = 1'b1;
      default:  loader_grant = 1'b1;
    endcase
  end

  assign ctl.pc_clr       = pc_clr;
  assign ctl.pc_inc       = pc_inc;
  assign ctl.pc_load      = pc_load;
  assign ctl.addr_sel     = addr_sel;
  assign ctl.mem_rd       = mem_rd;
  assign ctl.mem_wr       = mem_wr;
  assign ctl.ir_load      = ir_load;
  assign ctl.acc_load     = acc_load;
  assign ctl.alu_op       = alu_op;
  assign ctl.loader_grant = loader_grant;
  assign ctl.halted       = halted;
  assign ctl.instr_done   = instr_done;
  assign ctl.state        = state_q;

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: directed vector table, hand-written corner sequences and random
// stimulus checked against an instruction-level schedule model, on MEM_LAT=1 and MEM_LAT=3.
module tb_unidad_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [3:0] op = 4'h0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unidad_control_if u0_if ();
  unidad_control_if u1_if ();

  assign u0_if.run       = run;
  assign u0_if.ir_opcode = op;
  assign u1_if.run       = run;
  assign u1_if.ir_opcode = op;

  unidad_control #(.MEM_LAT(1)) u_dut0 (.clk(clk), .reset(reset), .ctl(u0_if));
  unidad_control #(.MEM_LAT(3)) u_dut1 (.clk(clk), .reset(reset), .ctl(u1_if));

  // Observed vector: {state, 11 flags, alu_op}
  wire [17:0] obs0 = {u0_if.state, u0_if.pc_clr, u0_if.pc_inc, u0_if.pc_load, u0_if.addr_sel,
                      u0_if.mem_rd, u0_if.mem_wr, u0_if.ir_load, u0_if.acc_load,
                      u0_if.loader_grant, u0_if.halted, u0_if.instr_done, u0_if.alu_op};
  wire [17:0] obs1 = {u1_if.state, u1_if.pc_clr, u1_if.pc_inc, u1_if.pc_load, u1_if.addr_sel,
                      u1_if.mem_rd, u1_if.mem_wr, u1_if.ir_load, u1_if.acc_load,
                      u1_if.loader_grant, u1_if.halted, u1_if.instr_done, u1_if.alu_op};

  localparam logic [10:0] F_CLR  = 11'h400;
  localparam logic [10:0] F_INC  = 11'h200;
  localparam logic [10:0] F_LD   = 11'h100;
  localparam logic [10:0] F_ASEL = 11'h080;
  localparam logic [10:0] F_RD   = 11'h040;
  localparam logic [10:0] F_WR   = 11'h020;
  localparam logic [10:0] F_IR   = 11'h010;
  localparam logic [10:0] F_ACC  = 11'h008;
  localparam logic [10:0] F_GNT  = 11'h004;
  localparam logic [10:0] F_HLT  = 11'h002;
  localparam logic [10:0] F_DONE = 11'h001;

  function automatic logic [17:0] vec(logic [2:0] st, logic [10:0] fl, logic [3:0] alu);
    return {st, fl, alu};
  endfunction

  function automatic logic [17:0] obs_of(int k);
    return (k == 0) ? obs0 : obs1;
  endfunction

  task automatic check(string name, logic [17:0] act, logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bounded wait, sampled 1 time unit after each falling edge, for a DUT state code.
  task automatic wait_state(string name, int k, logic [2:0] st);
    logic [17:0] o;
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      o = obs_of(k);
      if (o[17:15] == st) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 18'(found), 18'd1);
  endtask

  // Instruction-level reference: each instruction is expanded into a schedule of
  // cycle phases; phase numbers double as the published state codes.
  typedef enum int {PIdle, PClear, PFetch, PDecode, PRead, PExec, PWrite, PHalt} ph_e;
  typedef struct {
    ph_e ph;
    bit  last;
  } item_t;

  item_t       mq [2][$];
  item_t       cur [2];
  int unsigned lat [2];

  task automatic push_n(int k, ph_e ph, int unsigned n);
    item_t it;
    for (int unsigned i = 0; i < n; i++) begin
      it.ph   = ph;
      it.last = (i == n - 1);
      mq[k].push_back(it);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      cur[k].ph   = PIdle;
      cur[k].last = 1'b1;
    end
  endtask

  task automatic model_step(logic r, logic [3:0] o);
    for (int k = 0; k < 2; k++) begin
      if (mq[k].size() == 0) begin
        case (cur[k].ph)
          PIdle:   push_n(k, r ? PClear : PIdle, 1);
          PClear: begin
            push_n(k, PFetch, lat[k]);
            push_n(k, PDecode, 1);
          end
          PDecode: begin
            if (o == 4'h0)      push_n(k, PHalt, 1);
            else if (o == 4'h2) push_n(k, PWrite, 1);
            else begin
              push_n(k, PRead, lat[k]);
              push_n(k, PExec, 1);
            end
          end
          PExec, PWrite: begin
            if (r) begin
              push_n(k, PFetch, lat[k]);
              push_n(k, PDecode, 1);
            end else begin
              push_n(k, PIdle, 1);
            end
          end
          PHalt:   push_n(k, r ? PHalt : PIdle, 1);
          default: push_n(k, PIdle, 1);
        endcase
      end
      cur[k] = mq[k].pop_front();
    end
  endtask

  function automatic logic [17:0] model_exp(item_t it, logic [3:0] o);
    case (it.ph)
      PIdle:   return vec(3'd0, F_GNT, 4'h0);
      PClear:  return vec(3'd1, F_CLR, 4'h0);
      PFetch:  return vec(3'd2, F_RD | (it.last ? F_IR : 11'h0), 4'h0);
      PDecode: return vec(3'd3, (o != 4'h0) ? F_INC : 11'h0, 4'h0);
      PRead:   return vec(3'd4, F_ASEL | F_RD, 4'h0);
      PExec:   return vec(3'd5, F_DONE | ((o == 4'hB) ? F_LD : F_ACC), o);
      PWrite:  return vec(3'd6, F_ASEL | F_WR | F_DONE, 4'h0);
      default: return vec(3'd7, F_HLT, 4'h0);
    endcase
  endfunction

  // Hold reset for n cycles with run=0, release on a falling edge.
  task automatic do_reset(int n);
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  o;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [17:0] idle_v;
    logic [17:0] o;
    logic [17:0] exec_v;
    int          n;
    int          irl;
    bit          seen;

    idle_v = vec(3'd0, F_GNT, 4'h0);
    lat[0] = 1;
    lat[1] = 3;

    // LOAD, STORE, HALT at MEM_LAT=1; inputs and outputs of the same cycle
    tbl[0]  = '{1'b0, 4'h1, idle_v};
    tbl[1]  = '{1'b1, 4'h1, idle_v};
    tbl[2]  = '{1'b1, 4'h1, vec(3'd1, F_CLR, 4'h0)};
    tbl[3]  = '{1'b1, 4'h1, vec(3'd2, F_RD | F_IR, 4'h0)};
    tbl[4]  = '{1'b1, 4'h1, vec(3'd3, F_INC, 4'h0)};
    tbl[5]  = '{1'b1, 4'h1, vec(3'd4, F_ASEL | F_RD, 4'h0)};
    tbl[6]  = '{1'b1, 4'h1, vec(3'd5, F_ACC | F_DONE, 4'h1)};
    tbl[7]  = '{1'b1, 4'h2, vec(3'd2, F_RD | F_IR, 4'h0)};
    tbl[8]  = '{1'b1, 4'h2, vec(3'd3, F_INC, 4'h0)};
    tbl[9]  = '{1'b1, 4'h2, vec(3'd6, F_ASEL | F_WR | F_DONE, 4'h0)};
    tbl[10] = '{1'b1, 4'h0, vec(3'd2, F_RD | F_IR, 4'h0)};
    tbl[11] = '{1'b1, 4'h0, vec(3'd3, 11'h0, 4'h0)};
    tbl[12] = '{1'b1, 4'h0, vec(3'd7, F_HLT, 4'h0)};
    tbl[13] = '{1'b0, 4'h0, vec(3'd7, F_HLT, 4'h0)};
    tbl[14] = '{1'b0, 4'h0, idle_v};

    // Reset held 6 cycles, run toggling must not matter
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run = i[0];
      #1;
      check("reset_hold_lat1", obs0, idle_v);
      check("reset_hold_lat3", obs1, idle_v);
    end
    run = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("idle_after_release", obs0, idle_v);
    end

    do_reset(2);
    for (int i = 0; i < 15; i++) begin
      run = tbl[i].r;
      op  = tbl[i].o;
      #1;
      check($sformatf("table[%0d]", i), obs0, tbl[i].exp);
      @(negedge clk);
    end

    // JMP at MEM_LAT=3: FETCH*3, DECODE, READ*3, EXEC = 8 cycles
    do_reset(2);
    run = 1'b1;
    op  = 4'hB;
    wait_state("jmp_wait_fetch", 1, 3'd2);
    n      = 1;
    irl    = int'(u1_if.ir_load);
    exec_v = '0;
    seen   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      n++;
      irl += int'(u1_if.ir_load);
      if (u1_if.instr_done) begin
        exec_v = obs1;
        seen   = 1'b1;
        break;
      end
    end
    check("jmp_retired", 18'(seen), 18'd1);
    check("jmp_cycles", 18'(n), 18'd8);
    check("jmp_ir_loads", 18'(irl), 18'd1);
    check("jmp_exec", exec_v, vec(3'd5, F_LD | F_DONE, 4'hB));
    @(negedge clk);
    #1;
    check("jmp_next_fetch", obs1, vec(3'd2, F_RD, 4'h0));

    // HALT held for 10 cycles, leaves on run=0
    do_reset(2);
    run = 1'b1;
    op  = 4'h0;
    wait_state("halt_wait", 0, 3'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("halt_hold", obs0, vec(3'd7, F_HLT, 4'h0));
    end
    run = 1'b0;
    @(negedge clk);
    #1;
    check("halt_exit", obs0, idle_v);

    // run dropped during READ: EXEC still completes, then IDLE
    do_reset(2);
    run = 1'b1;
    op  = 4'h1;
    wait_state("rundrop_wait_read", 0, 3'd4);
    run = 1'b0;
    @(negedge clk);
    #1;
    check("rundrop_exec", obs0, vec(3'd5, F_ACC | F_DONE, 4'h1));
    @(negedge clk);
    #1;
    check("rundrop_idle", obs0, idle_v);

    // Reset mid-FETCH at MEM_LAT=3 aborts before ir_load
    do_reset(2);
    run = 1'b1;
    op  = 4'h1;
    wait_state("rstfetch_wait", 1, 3'd2);
    #1;
    reset = 1'b0;
    run   = 1'b0;
    #1;
    check("rstfetch_immediate", obs1, idle_v);
    repeat (4) begin
      @(negedge clk);
      #1;
      check("rstfetch_hold", obs1, idle_v);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rstfetch_release", obs1, idle_v);

    // Random stimulus against the schedule model on both latencies
    do_reset(2);
    for (int c = 0; c < 800; c++) begin
      if (!reset) begin
        reset = 1'b1;
      end
      run = ($urandom_range(0, 4) != 0);
      op  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
        model_reset();
      end
      #1;
      check("rand_lat1", obs0, model_exp(cur[0], op));
      check("rand_lat3", obs1, model_exp(cur[1], op));
      o = obs0;
      if (o[14:12] != 3'b000 && o[14:12] != 3'b100 && o[14:12] != 3'b010 &&
          o[14:12] != 3'b001) begin
        check("rand_pc_onehot", {15'h0, o[14:12]}, 18'h0);
      end
      @(posedge clk);
      if (reset) model_step(run, op);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
